key_click_decoder: RTL and testbench
====================================

Name: key_click_decoder

Overview:
Consumer end of the debounced-key interface. Takes the one-cycle "press confirmed" pulse from the key debouncer and groups pulses that arrive within a timing window into single, double or triple clicks. It emits one classified click event per group and maintains the OSD menu selection index derived from those events. It sits between the key debouncer and the OSD menu/overlay control logic.

Parameters:
WINDOW_CYC, 15_000_000, inter-click window in clk cycles (300 ms at 50 MHz); legal range is 2 or more.
TMR_W, 24, timer width; must satisfy 2^TMR_W > WINDOW_CYC.
MAX_CLICKS, 3, click count at which a group is reported immediately; fixed range is 2..3.
NUM_ITEMS, 4, number of menu entries; legal range is 2 or more.
SEL_W, 2, width of sel_idx; must satisfy 2^SEL_W >= NUM_ITEMS.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
key_pulse  input  1  one-cycle press pulse from the debouncer, synchronous to clk
click_valid  output  1  one-cycle strobe: a click group has been classified
click_num  output  2  clicks in the reported group (1..3); valid only while click_valid=1
single_click  output  1  one-cycle strobe, equals click_valid && click_num==1
double_click  output  1  one-cycle strobe, equals click_valid && click_num==2
triple_click  output  1  one-cycle strobe, equals click_valid && click_num==3
sel_idx  output  SEL_W  current menu selection
busy  output  1  high while a click group is open (state WAIT)

Behaviour:
- Clock and reset: clk is the clock. rst_n is an asynchronous, active-low reset. All state is reset asynchronously by rst_n.
- Reset values: state=IDLE, timer=0, cnt=0, click_valid=0, click_num=0, single/double/triple_click=0, sel_idx=0, busy=0.
- States:
  - IDLE: wait for a click.
  - WAIT: a click group is open.
  - REPORT: one-cycle emit.
- IDLE transitions:
  - key_pulse=1 -> WAIT, with cnt=1 and timer=0.
  - Otherwise remain in IDLE.
- WAIT, priority order:
  - key_pulse=1 and cnt+1==MAX_CLICKS -> REPORT with click_num=MAX_CLICKS.
  - key_pulse=1 otherwise -> stay in WAIT, cnt+1, timer=0 (window restarts).
  - timer==WINDOW_CYC-1 -> REPORT with click_num=cnt.
  - Otherwise timer+1.
- Simultaneous key_pulse and timeout in WAIT: the pulse wins. It is counted and the window restarts (or the group reports at MAX_CLICKS).
- REPORT:
  - Lasts exactly one cycle, then returns unconditionally to IDLE. cnt and timer are cleared.
  - key_pulse arriving in REPORT is dropped; it does not open a new group.
- Outputs are registered and asserted during the cycle the FSM is in REPORT:
  - click_valid=1 and click_num holds the count.
  - Exactly one of single/double/triple_click is high.
  - In every other cycle all strobes are 0 and click_num=0.
- Latency for timeout reports: click_valid is high in the cycle following clock edge k+WINDOW_CYC, where edge k sampled the last key_pulse of the group.
- Latency for MAX_CLICKS reports: click_valid is high in the cycle following the edge that sampled the final pulse.
- busy=1 exactly while the state is WAIT. busy is combinational from the state register.
- sel_idx updates on the same edge that enters REPORT:
  - Single click: +1, wrapping from NUM_ITEMS-1 to 0.
  - Double click: -1, wrapping from 0 to NUM_ITEMS-1.
  - Triple click: forced to 0.
  - sel_idx is otherwise held.
- Widths:
  - The timer saturates logic is not needed (it is bounded by the compare).
  - cnt is 2 bits and never exceeds MAX_CLICKS.
- Illegal state encodings recover to IDLE on the next edge.
- rst_n asserted mid-group: the group is discarded, no strobe is emitted, and sel_idx returns to 0.

Test Plan:
1. Use WINDOW_CYC=10. Apply one key_pulse at edge k -> busy from k+1; click_valid=1, click_num=1, single_click=1 in the cycle after edge k+10; sel_idx goes 0->1.
2. Apply two pulses 5 cycles apart -> one double_click, 10 cycles after the second pulse; sel_idx goes 0->3 (wrap); no single_click is ever asserted.
3. Apply three pulses 4 cycles apart -> triple_click the cycle after the third pulse is sampled (no window wait); sel_idx goes to 0; a fourth pulse during REPORT produces no further event.
4. Apply the second pulse exactly on the timeout edge (timer==9) -> it is counted; the result is double_click 10 cycles later, not single_click.
5. Apply four single clicks spaced 20 cycles apart -> sel_idx steps 1,2,3,0; there are exactly 4 click_valid strobes, each one cycle wide.
6. Apply one pulse, then assert rst_n low after 5 cycles and release it -> no strobe, busy=0, sel_idx=0; a fresh pulse afterwards is reported normally.

Source files
------------

// File: rtl/key_click_decoder.sv
// Groups debounced key pulses into single/double/triple click events and tracks the OSD menu index.
// Report is one cycle after the window expires or after the MAX_CLICKS-th pulse; no backpressure, pulses during report are dropped.
module key_click_decoder #(
    parameter int WINDOW_CYC = 15_000_000,
    parameter int TMR_W      = 24,
    parameter int MAX_CLICKS = 3,
    parameter int NUM_ITEMS  = 4,
    parameter int SEL_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_pulse,
    output logic             click_valid,
    output logic [1:0]       click_num,
    output logic             single_click,
    output logic             double_click,
    output logic             triple_click,
    output logic [SEL_W-1:0] sel_idx,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYC - 1);
    localparam logic [1:0]       MAX_CNT  = 2'(MAX_CLICKS);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_ITEMS - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       num_d;
    logic [1:0]       click_num_q;
    logic             click_valid_q;
    logic [SEL_W-1:0] sel_q, sel_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            cnt_q         <= 2'd0;
            click_valid_q <= 1'b0;
            click_num_q   <= 2'd0;
            sel_q         <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cnt_q         <= cnt_d;
            click_valid_q <= (state_d == REPORT);
            click_num_q   <= num_d;
            sel_q         <= sel_d;
        end
    end

    // A pulse in WAIT always beats the timeout on the same edge.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        num_d   = 2'd0;
        case (state_q)
            IDLE: begin
                if (key_pulse) begin
                    state_d = WAIT;
                    cnt_d   = 2'd1;
                    timer_d = '0;
                end
            end
            WAIT: begin
                if (key_pulse && (cnt_q + 2'd1 == MAX_CNT)) begin
                    state_d = REPORT;
                    num_d   = MAX_CNT;
                    cnt_d   = 2'd0;
                    timer_d = '0;
                end else if (key_pulse) begin
                    cnt_d   = cnt_q + 2'd1;
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d = REPORT;
                    num_d   = cnt_q;
                    cnt_d   = 2'd0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            REPORT: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
                timer_d = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        sel_d = sel_q;
        case (num_d)
            2'd1:    sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            2'd2:    sel_d = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
            2'd3:    sel_d = '0;
            default: sel_d = sel_q;
        endcase
    end

    assign click_valid  = click_valid_q;
    assign click_num    = click_num_q;
    assign single_click = click_valid_q && (click_num_q == 2'd1);
    assign double_click = click_valid_q && (click_num_q == 2'd2);
    assign triple_click = click_valid_q && (click_num_q == 2'd3);
    assign sel_idx      = sel_q;
    assign busy         = (state_q == WAIT);

endmodule

// File: tb/tb_key_click_decoder.sv
// Table-driven check of key_click_decoder with a 10-cycle click window.
module tb_key_click_decoder;

    localparam int WINDOW_CYC = 10;
    localparam int TMR_W      = 4;
    localparam int MAX_CLICKS = 3;
    localparam int NUM_ITEMS  = 4;
    localparam int SEL_W      = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_pulse;
    logic             click_valid;
    logic [1:0]       click_num;
    logic             single_click;
    logic             double_click;
    logic             triple_click;
    logic [SEL_W-1:0] sel_idx;
    logic             busy;

    key_click_decoder #(
        .WINDOW_CYC(WINDOW_CYC),
        .TMR_W     (TMR_W),
        .MAX_CLICKS(MAX_CLICKS),
        .NUM_ITEMS (NUM_ITEMS),
        .SEL_W     (SEL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_pulse   (key_pulse),
        .click_valid (click_valid),
        .click_num   (click_num),
        .single_click(single_click),
        .double_click(double_click),
        .triple_click(triple_click),
        .sel_idx     (sel_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       key;
        logic       vld;
        logic [1:0] num;
        logic       bsy;
        logic [1:0] sel;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic k, input logic v, input logic [1:0] n,
                       input logic b, input logic [1:0] s);
        vec_t e;
        e.key = k; e.vld = v; e.num = n; e.bsy = b; e.sel = s;
        vecs.push_back(e);
    endtask

    task automatic idle(input int n, input logic b, input logic [1:0] s);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 2'd0, b, s);
    endtask

    // One isolated click followed by quiet time: 20 cycles in total.
    task automatic one_click(input logic [1:0] s_before, input logic [1:0] s_after);
        add(1'b1, 1'b0, 2'd0, 1'b1, s_before);
        idle(9, 1'b1, s_before);
        add(1'b0, 1'b1, 2'd1, 1'b0, s_after);
        idle(9, 1'b0, s_after);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [1:0] n,
                            input logic b, input logic [1:0] s);
        chk({tag, " click_valid"},  32'(click_valid),  32'(v));
        chk({tag, " click_num"},    32'(click_num),    32'(n));
        chk({tag, " single_click"}, 32'(single_click), 32'(v && n == 2'd1));
        chk({tag, " double_click"}, 32'(double_click), 32'(v && n == 2'd2));
        chk({tag, " triple_click"}, 32'(triple_click), 32'(v && n == 2'd3));
        chk({tag, " busy"},         32'(busy),         32'(b));
        chk({tag, " sel_idx"},      32'(sel_idx),      32'(s));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int dut_reports;
    int exp_reports;
    int lat;

    initial begin
        // Four singles: 0 -> 1 -> 2 -> 3 -> 0
        for (int i = 0; i < 4; i++) one_click(2'(i), 2'(i + 1));
        // Double, pulses 5 apart: 0 -> 3
        add(1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
        idle(4, 1'b1, 2'd0);
        add(1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
        idle(9, 1'b1, 2'd0);
        add(1'b0, 1'b1, 2'd2, 1'b0, 2'd3);
        idle(2, 1'b0, 2'd3);
        // Triple, pulses 4 apart, reported immediately; fourth pulse lands in REPORT
        add(1'b1, 1'b0, 2'd0, 1'b1, 2'd3);
        idle(3, 1'b1, 2'd3);
        add(1'b1, 1'b0, 2'd0, 1'b1, 2'd3);
        idle(3, 1'b1, 2'd3);
        add(1'b1, 1'b1, 2'd3, 1'b0, 2'd0);
        add(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        idle(12, 1'b0, 2'd0);
        // Second pulse on the timeout edge is counted: double, 0 -> 3
        add(1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
        idle(9, 1'b1, 2'd0);
        add(1'b1, 1'b0, 2'd0, 1'b1, 2'd0);
        idle(9, 1'b1, 2'd0);
        add(1'b0, 1'b1, 2'd2, 1'b0, 2'd3);
        idle(2, 1'b0, 2'd3);

        exp_reports = 0;
        foreach (vecs[i]) if (vecs[i].vld) exp_reports++;

        key_pulse = 1'b0;
        rst_n     = 1'b0;
        #3;
        chk_outs("reset", 1'b0, 2'd0, 1'b0, 2'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_outs("post_reset", 1'b0, 2'd0, 1'b0, 2'd0);

        dut_reports = 0;
        foreach (vecs[i]) begin
            key_pulse = vecs[i].key;
            step();
            if (click_valid) dut_reports++;
            chk_outs($sformatf("vec%0d", i), vecs[i].vld, vecs[i].num, vecs[i].bsy, vecs[i].sel);
        end
        key_pulse = 1'b0;
        chk("report_count", 32'(dut_reports), 32'(exp_reports));
        chk("report_count_fixed", 32'(dut_reports), 32'd7);

        // Reset in the middle of an open group
        key_pulse = 1'b1;
        step();
        key_pulse = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk_outs("mid_rst", 1'b0, 2'd0, 1'b0, 2'd0);
        step();
        rst_n = 1'b1;
        dut_reports = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (click_valid || busy) dut_reports++;
        end
        chk("discarded_group_activity", 32'(dut_reports), 32'd0);
        chk("sel_after_rst", 32'(sel_idx), 32'd0);

        // Fresh click after reset must report normally
        key_pulse = 1'b1;
        step();
        key_pulse = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (click_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL fresh_click: no click_valid within 40 cycles, expected after 10");
        end else begin
            chk("fresh_latency", 32'(lat), 32'd10);
            chk_outs("fresh", 1'b1, 2'd1, 1'b0, 2'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
